// File: rtl/fetch_ctrl.sv
// Fetch-stage redirect arbiter and sequencer: picks one PC redirect per cycle,
// holds fetch during stalls, parks a redirect until the stall releases, and raises flushes.

package riscv_pkg;
    localparam int XLEN = 32;
endpackage

module fetch_ctrl #(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [XLEN-1:0]  pcF_i,
    input  logic             stall_i,
    input  logic             trap_req_i,
    input  logic [XLEN-1:0]  trap_vec_i,
    input  logic             mret_req_i,
    input  logic [XLEN-1:0]  mepc_i,
    input  logic             ex_redir_i,
    input  logic [XLEN-1:0]  ex_target_i,
    input  logic             id_redir_i,
    input  logic [XLEN-1:0]  id_target_i,
    output logic [XLEN-1:0]  next_pc_o,
    output logic             next_pc_enable_o,
    output logic             flush_fd_o,
    output logic             flush_de_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] redir_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    localparam logic [1:0] CLS_TRAP = 2'd3;
    localparam logic [1:0] CLS_MRET = 2'd2;
    localparam logic [1:0] CLS_EX   = 2'd1;
    localparam logic [1:0] CLS_ID   = 2'd0;

    state_t            state_r;
    state_t            state_nxt_s;

    logic              pend_valid_r;
    logic [1:0]        pend_class_r;
    logic [XLEN-1:0]   pend_target_r;
    logic              pend_mis_r;
    logic [CNT_W-1:0]  cnt_r;

    logic              win_valid_s;
    logic [1:0]        win_class_s;
    logic [XLEN-1:0]   win_raw_s;
    logic [XLEN-1:0]   win_target_s;
    logic              win_mis_s;
    logic              take_new_s;

    logic              apply_s;
    logic              pend_load_s;
    logic              pend_clear_s;
    logic [1:0]        sel_class_s;
    logic [XLEN-1:0]   sel_target_s;
    logic              sel_mis_s;

    logic [XLEN-1:0]   next_pc_s;
    logic              next_pc_en_s;
    logic              flush_fd_s;
    logic              flush_de_s;
    logic              misalign_s;

    // Fixed-priority pick of this cycle's redirect request; losers are simply dropped.
    always_comb begin
        win_valid_s = 1'b0;
        win_class_s = CLS_ID;
        win_raw_s   = {XLEN{1'b0}};
        if (trap_req_i) begin
            win_valid_s = 1'b1;
            win_class_s = CLS_TRAP;
            win_raw_s   = trap_vec_i;
        end else if (mret_req_i) begin
            win_valid_s = 1'b1;
            win_class_s = CLS_MRET;
            win_raw_s   = mepc_i;
        end else if (ex_redir_i) begin
            win_valid_s = 1'b1;
            win_class_s = CLS_EX;
            win_raw_s   = ex_target_i;
        end else if (id_redir_i) begin
            win_valid_s = 1'b1;
            win_class_s = CLS_ID;
            win_raw_s   = id_target_i;
        end else begin
            win_valid_s = 1'b0;
        end
    end

    assign win_target_s = {win_raw_s[XLEN-1:2], 2'b00};
    assign win_mis_s    = |win_raw_s[1:0];
    assign take_new_s   = win_valid_s && (win_class_s >= pend_class_r);

    // Next-state decision: hold, park or apply a redirect.
    always_comb begin
        state_nxt_s  = state_r;
        apply_s      = 1'b0;
        pend_load_s  = 1'b0;
        pend_clear_s = 1'b0;
        sel_class_s  = win_class_s;
        sel_target_s = win_target_s;
        sel_mis_s    = win_mis_s;
        case (state_r)
            ST_RUN, ST_HOLD: begin
                if (stall_i) begin
                    pend_load_s = win_valid_s;
                    state_nxt_s = win_valid_s ? ST_PEND : ST_HOLD;
                end else begin
                    apply_s     = win_valid_s;
                    state_nxt_s = ST_RUN;
                end
            end
            ST_PEND: begin
                if (stall_i) begin
                    pend_load_s = take_new_s;
                    state_nxt_s = ST_PEND;
                end else begin
                    apply_s      = 1'b1;
                    pend_clear_s = 1'b1;
                    state_nxt_s  = ST_RUN;
                    if (take_new_s || !pend_valid_r) begin
                        apply_s = win_valid_s || pend_valid_r;
                    end else begin
                        sel_class_s  = pend_class_r;
                        sel_target_s = pend_target_r;
                        sel_mis_s    = pend_mis_r;
                    end
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // Output drive; reset forces everything quiet so fetch's own reset vector wins.
    always_comb begin
        next_pc_s    = {XLEN{1'b0}};
        next_pc_en_s = 1'b0;
        flush_fd_s   = 1'b0;
        flush_de_s   = 1'b0;
        misalign_s   = 1'b0;
        if (!rstn_i) begin
            next_pc_en_s = 1'b0;
        end else if (stall_i) begin
            next_pc_s    = pcF_i;
            next_pc_en_s = 1'b1;
        end else if (apply_s) begin
            next_pc_s    = sel_target_s;
            next_pc_en_s = 1'b1;
            flush_fd_s   = 1'b1;
            flush_de_s   = (sel_class_s != CLS_ID);
            misalign_s   = sel_mis_s;
        end else begin
            next_pc_en_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Pending redirect slot: loaded or overwritten while stalled, cleared on release.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            pend_valid_r  <= 1'b0;
            pend_class_r  <= CLS_ID;
            pend_target_r <= {XLEN{1'b0}};
            pend_mis_r    <= 1'b0;
        end else if (pend_load_s) begin
            pend_valid_r  <= 1'b1;
            pend_class_r  <= win_class_s;
            pend_target_r <= win_target_s;
            pend_mis_r    <= win_mis_s;
        end else if (pend_clear_s) begin
            pend_valid_r  <= 1'b0;
            pend_class_r  <= CLS_ID;
        end else begin
            pend_valid_r  <= pend_valid_r;
        end
    end

    // Applied-redirect counter, wraps naturally.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (apply_s) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign next_pc_o        = next_pc_s;
    assign next_pc_enable_o = next_pc_en_s;
    assign flush_fd_o       = flush_fd_s;
    assign flush_de_o       = flush_de_s;
    assign misalign_o       = misalign_s;
    assign redir_cnt_o      = cnt_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a tiny fetch-PC model closing the loop on pcF_i.

module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] pc_f = 32'h8000_0000;
    logic        stall, trap, mret, ex, id;
    logic [31:0] tv, mepc, et, it;
    logic [31:0] npc;
    logic        en, ffd, fde, mis;
    logic [31:0] cnt;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        rstn, stall, trap;
        logic [31:0] tv;
        logic        mret;
        logic [31:0] mepc;
        logic        ex;
        logic [31:0] et;
        logic        id;
        logic [31:0] it;
        logic [31:0] pc, npc;
        logic        en, ffd, fde, mis;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];

    fetch_ctrl #(.XLEN(32), .CNT_W(32)) dut (
        .clk_i(clk), .rstn_i(rstn), .pcF_i(pc_f), .stall_i(stall),
        .trap_req_i(trap), .trap_vec_i(tv), .mret_req_i(mret), .mepc_i(mepc),
        .ex_redir_i(ex), .ex_target_i(et), .id_redir_i(id), .id_target_i(it),
        .next_pc_o(npc), .next_pc_enable_o(en), .flush_fd_o(ffd),
        .flush_de_o(fde), .misalign_o(mis), .redir_cnt_o(cnt)
    );

    always #5 clk = ~clk;

    // Fetch stage model: reset vector, redirect/hold via enable, else sequential.
    always @(posedge clk) begin
        if (!rstn)    pc_f <= 32'h8000_0000;
        else if (en)  pc_f <= npc;
        else          pc_f <= pc_f + 32'd4;
    end

    function automatic vec_t row(logic r, logic s, logic tr, logic [31:0] tvv, logic mr,
                                 logic [31:0] mp, logic e, logic [31:0] etv, logic d,
                                 logic [31:0] itv, logic [31:0] pc, logic [31:0] np,
                                 logic x_en, logic x_ffd, logic x_fde, logic x_mis,
                                 logic [31:0] c);
        vec_t v;
        v.rstn = r;  v.stall = s;  v.trap = tr; v.tv = tvv; v.mret = mr; v.mepc = mp;
        v.ex = e;    v.et = etv;   v.id = d;    v.it = itv; v.pc = pc;   v.npc = np;
        v.en = x_en; v.ffd = x_ffd; v.fde = x_fde; v.mis = x_mis; v.cnt = c;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(vec_t v, string tag);
        rstn = v.rstn; stall = v.stall; trap = v.trap; tv = v.tv; mret = v.mret;
        mepc = v.mepc; ex = v.ex; et = v.et; id = v.id; it = v.it;
        @(negedge clk);
        chk({tag, "_pcF"}, pc_f, v.pc);
        chk({tag, "_npc"}, npc, v.npc);
        chk({tag, "_en"},  {31'd0, en},  {31'd0, v.en});
        chk({tag, "_ffd"}, {31'd0, ffd}, {31'd0, v.ffd});
        chk({tag, "_fde"}, {31'd0, fde}, {31'd0, v.fde});
        chk({tag, "_mis"}, {31'd0, mis}, {31'd0, v.mis});
        chk({tag, "_cnt"}, cnt, v.cnt);
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] Z  = 32'h0000_0000;
    localparam logic [31:0] B  = 32'h8000_0000;

    initial begin
        rstn = 1'b0; stall = 1'b0; trap = 1'b0; mret = 1'b0; ex = 1'b0; id = 1'b0;
        tv = Z; mepc = Z; et = Z; it = Z;
        repeat (2) @(posedge clk);
        #1;

        //           rstn  stl   trap  tv         mret  mepc       ex    et         id    it         pcF        npc        en    ffd   fde   mis   cnt
        vecs.push_back(row(1'b0,1'b0,1'b0,Z,        1'b0,Z,        1'b1,B+32'h100,1'b0,Z,        B,         Z,         1'b0,1'b0,1'b0,1'b0,32'd0));
        vecs.push_back(row(1'b1,1'b0,1'b0,Z,        1'b0,Z,        1'b0,Z,        1'b0,Z,        B,         Z,         1'b0,1'b0,1'b0,1'b0,32'd0));
        vecs.push_back(row(1'b1,1'b0,1'b0,Z,        1'b0,Z,        1'b0,Z,        1'b0,Z,        B+32'h4,   Z,         1'b0,1'b0,1'b0,1'b0,32'd0));
        vecs.push_back(row(1'b1,1'b0,1'b0,Z,        1'b0,Z,        1'b0,Z,        1'b0,Z,        B+32'h8,   Z,         1'b0,1'b0,1'b0,1'b0,32'd0));
        vecs.push_back(row(1'b1,1'b0,1'b0,Z,        1'b0,Z,        1'b1,B+32'h100,1'b1,B+32'h40, B+32'hC,   B+32'h100, 1'b1,1'b1,1'b1,1'b0,32'd0));
        vecs.push_back(row(1'b1,1'b0,1'b0,Z,        1'b0,Z,        1'b0,Z,        1'b1,B+32'h10, B+32'h100, B+32'h10,  1'b1,1'b1,1'b0,1'b0,32'd1));
        vecs.push_back(row(1'b1,1'b1,1'b0,Z,        1'b0,Z,        1'b0,Z,        1'b0,Z,        B+32'h10,  B+32'h10,  1'b1,1'b0,1'b0,1'b0,32'd2));
        vecs.push_back(row(1'b1,1'b1,1'b0,Z,        1'b0,Z,        1'b0,Z,        1'b0,Z,        B+32'h10,  B+32'h10,  1'b1,1'b0,1'b0,1'b0,32'd2));
        vecs.push_back(row(1'b1,1'b1,1'b0,Z,        1'b0,Z,        1'b0,Z,        1'b0,Z,        B+32'h10,  B+32'h10,  1'b1,1'b0,1'b0,1'b0,32'd2));
        vecs.push_back(row(1'b1,1'b0,1'b0,Z,        1'b0,Z,        1'b0,Z,        1'b0,Z,        B+32'h10,  Z,         1'b0,1'b0,1'b0,1'b0,32'd2));
        vecs.push_back(row(1'b1,1'b0,1'b0,Z,        1'b0,Z,        1'b0,Z,        1'b0,Z,        B+32'h14,  Z,         1'b0,1'b0,1'b0,1'b0,32'd2));
        vecs.push_back(row(1'b1,1'b1,1'b0,Z,        1'b0,Z,        1'b0,Z,        1'b1,B+32'h200,B+32'h18,  B+32'h18,  1'b1,1'b0,1'b0,1'b0,32'd2));
        vecs.push_back(row(1'b1,1'b1,1'b0,Z,        1'b0,Z,        1'b1,B+32'h300,1'b0,Z,        B+32'h18,  B+32'h18,  1'b1,1'b0,1'b0,1'b0,32'd2));
        vecs.push_back(row(1'b1,1'b1,1'b0,Z,        1'b0,Z,        1'b0,Z,        1'b1,B+32'h400,B+32'h18,  B+32'h18,  1'b1,1'b0,1'b0,1'b0,32'd2));
        vecs.push_back(row(1'b1,1'b0,1'b0,Z,        1'b0,Z,        1'b0,Z,        1'b0,Z,        B+32'h18,  B+32'h300, 1'b1,1'b1,1'b1,1'b0,32'd2));
        vecs.push_back(row(1'b1,1'b0,1'b0,Z,        1'b0,Z,        1'b0,Z,        1'b0,Z,        B+32'h300, Z,         1'b0,1'b0,1'b0,1'b0,32'd3));
        vecs.push_back(row(1'b1,1'b1,1'b1,B+32'h800,1'b1,B+32'h900,1'b0,Z,        1'b0,Z,        B+32'h304, B+32'h304, 1'b1,1'b0,1'b0,1'b0,32'd3));
        vecs.push_back(row(1'b1,1'b0,1'b0,Z,        1'b1,B+32'h900,1'b0,Z,        1'b0,Z,        B+32'h304, B+32'h800, 1'b1,1'b1,1'b1,1'b0,32'd3));
        vecs.push_back(row(1'b1,1'b0,1'b0,Z,        1'b0,Z,        1'b0,Z,        1'b0,Z,        B+32'h800, Z,         1'b0,1'b0,1'b0,1'b0,32'd4));
        vecs.push_back(row(1'b1,1'b1,1'b0,Z,        1'b0,Z,        1'b1,B+32'h500,1'b0,Z,        B+32'h804, B+32'h804, 1'b1,1'b0,1'b0,1'b0,32'd4));
        vecs.push_back(row(1'b1,1'b0,1'b0,Z,        1'b0,Z,        1'b1,B+32'h600,1'b0,Z,        B+32'h804, B+32'h600, 1'b1,1'b1,1'b1,1'b0,32'd4));
        vecs.push_back(row(1'b1,1'b0,1'b0,Z,        1'b0,Z,        1'b1,B+32'h102,1'b0,Z,        B+32'h600, B+32'h100, 1'b1,1'b1,1'b1,1'b1,32'd5));
        vecs.push_back(row(1'b1,1'b0,1'b0,Z,        1'b0,Z,        1'b0,Z,        1'b0,Z,        B+32'h100, Z,         1'b0,1'b0,1'b0,1'b0,32'd6));
        vecs.push_back(row(1'b1,1'b0,1'b1,B+32'h803,1'b1,B+32'h900,1'b1,B+32'h300,1'b1,B+32'h400,B+32'h104, B+32'h800, 1'b1,1'b1,1'b1,1'b1,32'd6));
        vecs.push_back(row(1'b1,1'b0,1'b0,Z,        1'b0,Z,        1'b0,Z,        1'b1,B+32'h42, B+32'h800, B+32'h40,  1'b1,1'b1,1'b0,1'b1,32'd7));
        vecs.push_back(row(1'b1,1'b1,1'b0,Z,        1'b0,Z,        1'b1,B+32'h300,1'b0,Z,        B+32'h40,  B+32'h40,  1'b1,1'b0,1'b0,1'b0,32'd8));
        vecs.push_back(row(1'b0,1'b1,1'b0,Z,        1'b0,Z,        1'b0,Z,        1'b0,Z,        B+32'h40,  Z,         1'b0,1'b0,1'b0,1'b0,32'd8));
        vecs.push_back(row(1'b1,1'b0,1'b0,Z,        1'b0,Z,        1'b0,Z,        1'b0,Z,        B,         Z,         1'b0,1'b0,1'b0,1'b0,32'd0));
        vecs.push_back(row(1'b1,1'b0,1'b0,Z,        1'b0,Z,        1'b0,Z,        1'b0,Z,        B+32'h4,   Z,         1'b0,1'b0,1'b0,1'b0,32'd0));
        vecs.push_back(row(1'b1,1'b1,1'b0,Z,        1'b0,Z,        1'b0,Z,        1'b0,Z,        B+32'h8,   B+32'h8,   1'b1,1'b0,1'b0,1'b0,32'd0));
        vecs.push_back(row(1'b1,1'b0,1'b0,Z,        1'b1,B+32'hA00,1'b0,Z,        1'b0,Z,        B+32'h8,   B+32'hA00, 1'b1,1'b1,1'b1,1'b0,32'd0));
        vecs.push_back(row(1'b1,1'b0,1'b0,Z,        1'b0,Z,        1'b0,Z,        1'b0,Z,        B+32'hA00, Z,         1'b0,1'b0,1'b0,1'b0,32'd1));

        foreach (vecs[i]) step(vecs[i], $sformatf("row%0d", i));

        // Back-to-back redirects in RUN: each one counts, id jumps never flush ID/EX.
        step(row(1'b1,1'b0,1'b0,Z,1'b0,Z,1'b1,B+32'h700,1'b0,Z,        B+32'hA04,B+32'h700,1'b1,1'b1,1'b1,1'b0,32'd1), "b2b_ex");
        step(row(1'b1,1'b0,1'b0,Z,1'b0,Z,1'b0,Z,        1'b1,B+32'h710,B+32'h700,B+32'h710,1'b1,1'b1,1'b0,1'b0,32'd2), "b2b_id");
        step(row(1'b1,1'b0,1'b0,Z,1'b0,Z,1'b0,Z,        1'b0,Z,        B+32'h710,Z,        1'b0,1'b0,1'b0,1'b0,32'd3), "b2b_idle");

        // Trap arriving late in a stall overrides a parked ex redirect.
        step(row(1'b1,1'b1,1'b0,Z,        1'b0,Z,1'b1,B+32'h300,1'b0,Z,B+32'h714,B+32'h714,1'b1,1'b0,1'b0,1'b0,32'd3), "late_ex");
        step(row(1'b1,1'b1,1'b1,B+32'hC00,1'b0,Z,1'b0,Z,        1'b0,Z,B+32'h714,B+32'h714,1'b1,1'b0,1'b0,1'b0,32'd3), "late_trap");
        step(row(1'b1,1'b0,1'b0,Z,        1'b0,Z,1'b1,B+32'h500,1'b0,Z,B+32'h714,B+32'hC00,1'b1,1'b1,1'b1,1'b0,32'd3), "late_rel");
        step(row(1'b1,1'b0,1'b0,Z,        1'b0,Z,1'b0,Z,        1'b0,Z,B+32'hC00,Z,        1'b0,1'b0,1'b0,1'b0,32'd4), "late_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
